// File: rtl/rhd_spi_pkg.sv
// Shared definitions for the RHD headstage SPI master: FSM encoding, frame geometry
// and the headstage command word encodings.
package rhd_spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int SCLK_DIV  = 4;
  localparam int WORD_BITS = 16;

  localparam logic [15:0] RHD_CALIBRATE = 16'h5500;

  function automatic logic [15:0] rhd_convert(input logic [5:0] ch);
    return {2'b00, ch, 8'h00};
  endfunction

  function automatic logic [15:0] rhd_read(input logic [5:0] reg_addr);
    return 16'hC000 | {2'b00, reg_addr, 8'h00};
  endfunction

  function automatic logic [15:0] rhd_write(input logic [5:0] reg_addr, input logic [7:0] val);
    return 16'h8000 | {2'b00, reg_addr, 8'h00} | {8'h00, val};
  endfunction

endpackage

// File: rtl/rhd_spi_ddr_capture.sv
// Dual-data-rate MISO capture: delays the FSM's A/B sample strobes by MISO_DELAY
// cycles and shifts MISO, MSB first, into the A and B words.
module rhd_spi_ddr_capture
  import rhd_spi_pkg::*;
#(
  parameter int MISO_DELAY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 strobe_a,
  input  logic                 strobe_b,
  input  logic                 miso,
  output logic [WORD_BITS-1:0] word_a,
  output logic [WORD_BITS-1:0] word_b
);

  // Bit 0 is the undelayed strobe; bit MISO_DELAY is the one that actually samples.
  logic [MISO_DELAY:0]   dly_a, dly_b;
  logic                  en_a, en_b;
  logic [WORD_BITS-1:0]  sh_a, sh_b;

  if (MISO_DELAY == 0) begin : g_nodly
    assign dly_a = strobe_a;
    assign dly_b = strobe_b;
  end else begin : g_dly
    logic [MISO_DELAY-1:0] q_a, q_b;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_a <= '0;
        q_b <= '0;
      end else begin
        q_a <= dly_a[MISO_DELAY-1:0];
        q_b <= dly_b[MISO_DELAY-1:0];
      end
    end
    assign dly_a = {q_a, strobe_a};
    assign dly_b = {q_b, strobe_b};
  end

  assign en_a = dly_a[MISO_DELAY];
  assign en_b = dly_b[MISO_DELAY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
    end else begin
      if (en_a) sh_a <= {sh_a[WORD_BITS-2:0], miso};
      if (en_b) sh_b <= {sh_b[WORD_BITS-2:0], miso};
    end
  end

  // Look-ahead view so the final B bit can be loaded on the same edge it is sampled.
  assign word_a = en_a ? {sh_a[WORD_BITS-2:0], miso} : sh_a;
  assign word_b = en_b ? {sh_b[WORD_BITS-2:0], miso} : sh_b;

endmodule

// File: rtl/rhd_spi_master.sv
// SPI master for one RHD headstage: sends a 16-bit command per frame and returns the
// two DDR result words (A on SCLK-high phase, B on SCLK-low phase) tagged by channel.
module rhd_spi_master
  import rhd_spi_pkg::*;
#(
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_HIGH_MIN = 8,
  parameter int MISO_DELAY  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WORD_BITS-1:0] cmd_data,
  input  logic [5:0]           cmd_channel,
  output logic                 CS,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic [5:0]           channel,
  output logic                 rsp_valid,
  output logic [WORD_BITS-1:0] rsp_a,
  output logic [WORD_BITS-1:0] rsp_b,
  output logic [5:0]           rsp_channel,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  // HOLD must outlast the last (delayed) B sample, which lands at HOLD cycle 1+MISO_DELAY.
  localparam int HOLD_LEN = (CS_HOLD > 2 + MISO_DELAY) ? CS_HOLD : 2 + MISO_DELAY;
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_LEN - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_HIGH_MIN - 1);
  localparam logic [1:0] PH_RISE    = 2'(SCLK_DIV / 2 - 1);
  localparam logic [1:0] PH_LAST    = 2'(SCLK_DIV - 1);

  logic [2:0]           state;
  logic [7:0]           cnt;
  logic [1:0]           phase;
  logic [3:0]           bit_cnt;
  logic [WORD_BITS-1:0] cmd_sh;
  logic                 strobe_a, strobe_b;
  logic [WORD_BITS-1:0] word_a, word_b;

  assign dbg_state = state;

  // A closes each SCLK-high half; B closes the following low half (first period has none).
  assign strobe_a = (state == ST_SHIFT) && (phase == PH_LAST);
  assign strobe_b = ((state == ST_SHIFT) && (phase == PH_RISE) && (bit_cnt != 4'd15)) ||
                    ((state == ST_HOLD) && (cnt == 8'd1));

  rhd_spi_ddr_capture #(.MISO_DELAY(MISO_DELAY)) u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_a (strobe_a),
    .strobe_b (strobe_b),
    .miso     (MISO),
    .word_a   (word_a),
    .word_b   (word_b)
  );

  // Handshake: a command transfers on any rising clk edge where cmd_valid and cmd_ready
  // are both high; cmd_ready is high only in IDLE and the upstream holds its offer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      CS          <= 1'b1;
      SCLK        <= 1'b0;
      MOSI        <= 1'b0;
      channel     <= '0;
      rsp_valid   <= 1'b0;
      rsp_a       <= '0;
      rsp_b       <= '0;
      rsp_channel <= '0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_sh    <= cmd_data;
            channel   <= cmd_channel;
            CS        <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            phase   <= '0;
            bit_cnt <= 4'd15;
            MOSI    <= cmd_sh[WORD_BITS-1];
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          phase <= phase + 2'd1;
          if (phase == PH_RISE) SCLK <= 1'b1;
          if (phase == PH_LAST) begin
            SCLK <= 1'b0;
            if (bit_cnt == 4'd0) begin
              cnt   <= '0;
              state <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
              cmd_sh  <= {cmd_sh[WORD_BITS-2:0], 1'b0};
              MOSI    <= cmd_sh[WORD_BITS-2];
            end
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rsp_a       <= word_a;
            rsp_b       <= word_b;
            rsp_channel <= channel;
            rsp_valid   <= 1'b1;
            CS          <= 1'b1;
            MOSI        <= 1'b0;
            cnt         <= '0;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          CS        <= 1'b1;
          SCLK      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
